// File: rtl/block_transfer_engine.sv
// Miss-service engine: writes a dirty victim block back to main memory word by
// word, then reads the refill block and streams it into the cache data array.
module block_transfer_engine #(
    parameter int  DATA_W   = 32,
    parameter int  BLK_W    = 8,
    parameter int  WORDS    = 16,
    parameter int  MAX_WAIT = 64,
    localparam int IDX_W    = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wb,
    input  logic [BLK_W-1:0]       req_wb_blk,
    input  logic [BLK_W-1:0]       req_fill_blk,
    output logic [IDX_W-1:0]       wb_word_idx,
    input  logic [DATA_W-1:0]      wb_word,
    output logic                   fill_valid,
    output logic [IDX_W-1:0]       fill_word_idx,
    output logic [DATA_W-1:0]      fill_word,
    output logic                   done,
    output logic                   err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [BLK_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ack,
    output logic [15:0]            xfer_cnt
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BLK_W-1:0]  wb_blk;
    logic [BLK_W-1:0]  fill_blk;
    logic              timed_out;
    logic              last_word;
    logic              beat_ack;

    // wait_cnt only moves during a beat, so the limit compare needs no state qualifier.
    assign timed_out = (wait_cnt == WAIT_LIM);
    assign last_word = (idx == LAST_IDX);
    assign beat_ack  = mem_req && mem_ack;

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wb_word_idx = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_wb ? WB : FILL;
                end
            end
            WB: begin
                if (timed_out) begin
                    err        = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_req     = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = {wb_blk, idx};
                    wb_word_idx = idx;
                    mem_wdata   = wb_word;
                    if (mem_ack && last_word) begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (timed_out) begin
                    err        = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = {fill_blk, idx};
                    if (mem_ack && last_word) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            wb_blk        <= '0;
            fill_blk      <= '0;
            fill_valid    <= 1'b0;
            fill_word_idx <= '0;
            fill_word     <= '0;
            xfer_cnt      <= '0;
        end else begin
            state      <= state_next;
            fill_valid <= 1'b0;
            if (req_valid && req_ready) begin
                wb_blk   <= req_wb_blk;
                fill_blk <= req_fill_blk;
                idx      <= '0;
            end
            // idx wraps to 0 after the last word, which starts the fill at word 0.
            if (beat_ack) begin
                idx      <= idx + IDX_W'(1);
                wait_cnt <= '0;
                if (state == FILL) begin
                    fill_valid    <= 1'b1;
                    fill_word     <= mem_rdata;
                    fill_word_idx <= idx;
                end
            end else if (mem_req) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state == DONE && xfer_cnt != 16'hFFFF) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_block_transfer_engine.sv
// Bench for block_transfer_engine: memory/cache models, a request-level
// reference model with expected queues, and directed miss scenarios.
module tb_block_transfer_engine;

    localparam int DATA_W   = 32;
    localparam int BLK_W    = 8;
    localparam int WORDS    = 16;
    localparam int MAX_WAIT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wb = 1'b0;
    logic [7:0]  req_wb_blk = 8'h00;
    logic [7:0]  req_fill_blk = 8'h00;
    logic [3:0]  wb_word_idx;
    logic [31:0] wb_word;
    logic        fill_valid;
    logic [3:0]  fill_word_idx;
    logic [31:0] fill_word;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [15:0] xfer_cnt;

    block_transfer_engine #(
        .DATA_W(DATA_W), .BLK_W(BLK_W), .WORDS(WORDS), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_wb_blk(req_wb_blk), .req_fill_blk(req_fill_blk),
        .wb_word_idx(wb_word_idx), .wb_word(wb_word),
        .fill_valid(fill_valid), .fill_word_idx(fill_word_idx), .fill_word(fill_word),
        .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Slave memory (written by the DUT), reference memory (written by the model), victim line.
    logic [31:0] mem [4096];
    logic [31:0] model_mem [4096];
    logic [31:0] victim [16];
    assign wb_word = victim[wb_word_idx];

    int ack_delay = 0;
    bit stall_en = 1'b0;
    bit stray_ack = 1'b0;
    int beat_wait = 0;

    logic [43:0] exp_wr_q[$];
    logic [11:0] exp_rd_q[$];
    logic [35:0] exp_fill_q[$];
    logic [35:0] fill_log[$];
    logic [11:0] rd_log[$];

    int mon_cyc = 0;
    int accept_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_accept_cyc = 0;
    int last_done_cyc = 0;
    int last_err_cyc = 0;
    int beat5_start = -1;
    int fill_left = 0;
    int exp_done_cyc = 0;
    bit pending = 1'b0;
    bit zero_wait_req = 1'b0;
    bit err_expected = 1'b0;
    logic [15:0] model_xfer = 16'h0;
    bit prev_wait = 1'b0;
    logic [11:0] prev_addr = 12'h0;

    int total_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, mon_cyc);
    endtask

    // Memory responder: decides ack/rdata for the cycle just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        mem_ack = stray_ack ||
                  (mem_req && beat_wait >= ack_delay &&
                   !(stall_en && !mem_we && mem_addr[3:0] == 4'd5));
        mem_rdata = (mem_req && !mem_we) ? mem[mem_addr] : 32'hDEAD_BEEF;
    end

    // Compare process: checks every cycle against the request-level model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            exp_fill_q.delete();
            pending = 1'b0;
            model_xfer = 16'h0;
            prev_wait = 1'b0;
            beat_wait = 0;
        end else begin
            mon_cyc++;
            check("xfer_cnt", xfer_cnt, model_xfer);
            check("req_ready", req_ready, !pending);
            if (mem_req) check("mem_req_pending", pending, 1);
            if (prev_wait && mem_req) check("addr_hold", mem_addr, prev_addr);
            if (stall_en && mem_req && !mem_we && mem_addr[3:0] == 4'd5 && beat5_start < 0)
                beat5_start = mon_cyc;

            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    check("wr_avail", exp_wr_q.size() > 0, 1);
                    if (exp_wr_q.size() > 0) check("wr_beat", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
                    mem[mem_addr] = mem_wdata;
                end else begin
                    check("wb_before_fill", exp_wr_q.size(), 0);
                    check("rd_avail", exp_rd_q.size() > 0, 1);
                    if (exp_rd_q.size() > 0) check("rd_addr", mem_addr, exp_rd_q.pop_front());
                    rd_log.push_back(mem_addr);
                end
            end

            if (fill_valid) begin
                check("fill_avail", exp_fill_q.size() > 0, 1);
                if (exp_fill_q.size() > 0) check("fill_strobe", {fill_word_idx, fill_word}, exp_fill_q.pop_front());
                fill_log.push_back({fill_word_idx, fill_word});
            end

            if (done) begin
                check("done_expected",
                      {pending, exp_wr_q.size() == 0, exp_rd_q.size() == 0, exp_fill_q.size() == 0}, 4'hF);
                if (zero_wait_req) check("done_cycle", mon_cyc, exp_done_cyc);
                pending = 1'b0;
                done_cnt++;
                last_done_cyc = mon_cyc;
                if (model_xfer != 16'hFFFF) model_xfer++;
            end

            if (err) begin
                check("err_expected", {err_expected, pending}, 2'b11);
                check("err_cycle", mon_cyc, beat5_start + MAX_WAIT);
                fill_left = exp_fill_q.size();
                exp_wr_q.delete();
                exp_rd_q.delete();
                exp_fill_q.delete();
                pending = 1'b0;
                err_cnt++;
                last_err_cyc = mon_cyc;
            end

            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (mem_req && mem_ack) beat_wait = 0;
            else if (mem_req) beat_wait++;
            else beat_wait = 0;

            if (req_valid && req_ready) begin
                if (req_wb) begin
                    for (int k = 0; k < 16; k++) begin
                        exp_wr_q.push_back({req_wb_blk, 4'(k), victim[k]});
                        model_mem[{req_wb_blk, 4'(k)}] = victim[k];
                    end
                end
                for (int k = 0; k < 16; k++) begin
                    exp_rd_q.push_back({req_fill_blk, 4'(k)});
                    exp_fill_q.push_back({4'(k), model_mem[{req_fill_blk, 4'(k)}]});
                end
                pending = 1'b1;
                accept_cnt++;
                last_accept_cyc = mon_cyc;
                zero_wait_req = (ack_delay == 0) && !stall_en;
                exp_done_cyc = mon_cyc + (req_wb ? 33 : 17);
            end
        end
    end

    task automatic wait_accept(input int start, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (accept_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        check("accept_seen", seen, 1);
    endtask

    task automatic send_req(input bit wb, input logic [7:0] wblk, input logic [7:0] fblk);
        int start = accept_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wb = wb;
        req_wb_blk = wblk;
        req_fill_blk = fblk;
        wait_accept(start, 200);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int start_d = done_cnt;
        int start_e = err_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != start_d || err_cnt != start_e) begin
                seen = 1'b1;
                break;
            end
        end
        check("end_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_before;
        int done1;
        bit found;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'hC000_0000 | 32'(i);
            model_mem[i] = 32'hC000_0000 | 32'(i);
        end
        for (int k = 0; k < 16; k++) begin
            mem[{8'h02, 4'(k)}] = 32'h100 + 32'(k);
            model_mem[{8'h02, 4'(k)}] = 32'h100 + 32'(k);
            victim[k] = 32'hA0 + 32'(k);
        end

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_outputs", {mem_req, mem_we, fill_valid, done, err}, 5'b0);
        check("rst_addr", mem_addr, 12'h000);
        check("rst_xfer", xfer_cnt, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill-only, block 0x02
        fill_log.delete();
        send_req(1'b0, 8'h00, 8'h02);
        wait_end(200);
        check("t1_latency", last_done_cyc - last_accept_cyc, 17);
        check("t1_nstrobe", fill_log.size(), 16);
        check("t1_first", fill_log[0], {4'h0, 32'h0000_0100});
        check("t1_last", fill_log[15], {4'hF, 32'h0000_010F});
        @(negedge clk);
        #2;
        check("t1_xfer", xfer_cnt, 16'd1);
        check("t1_ready", req_ready, 1);

        // Dirty miss: write back 0x85, fill 0x05
        rd_log.delete();
        send_req(1'b1, 8'h85, 8'h05);
        wait_end(200);
        check("t2_latency", last_done_cyc - last_accept_cyc, 33);
        check("t2_wb_first", mem[12'h850], 32'h0000_00A0);
        check("t2_wb_last", mem[12'h85F], 32'h0000_00AF);
        check("t2_rd_count", rd_log.size(), 16);
        check("t2_rd_first", rd_log[0], 12'h050);
        check("t2_rd_last", rd_log[15], 12'h05F);

        // Victim and refill in the same block: fill must see the written-back data
        fill_log.delete();
        send_req(1'b1, 8'h33, 8'h33);
        wait_end(200);
        check("t3_nstrobe", fill_log.size(), 16);
        check("t3_word3", fill_log[3], {4'h3, 32'h0000_00A3});

        // Wait states: ack every 3rd cycle
        fill_log.delete();
        ack_delay = 2;
        send_req(1'b0, 8'h00, 8'h11);
        wait_end(400);
        check("t4_latency", last_done_cyc - last_accept_cyc, 49);
        check("t4_nstrobe", fill_log.size(), 16);
        check("t4_last", fill_log[15], {4'hF, 32'hC000_011F});
        ack_delay = 0;

        // Timeout on fill beat 5
        fill_log.delete();
        d_before = done_cnt;
        beat5_start = -1;
        stall_en = 1'b1;
        err_expected = 1'b1;
        send_req(1'b0, 8'h00, 8'h02);
        wait_end(300);
        check("t5_err_latency", last_err_cyc - last_accept_cyc, 70);
        check("t5_strobes", fill_log.size(), 5);
        check("t5_left", fill_left, 11);
        check("t5_no_done", done_cnt, d_before);
        @(negedge clk);
        #2;
        check("t5_after_req", mem_req, 0);
        check("t5_after_ready", req_ready, 1);
        check("t5_xfer", xfer_cnt, 16'd4);
        stall_en = 1'b0;
        err_expected = 1'b0;

        // Reset during the write-back beat at idx 7
        send_req(1'b1, 8'h40, 8'h41);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (mem_req && mem_we && mem_addr[3:0] == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reached_idx7", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {mem_req, fill_valid, done, err}, 4'b0);
        check("t6_rst_ready", req_ready, 1);
        check("t6_rst_xfer", xfer_cnt, 16'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("t6_idle_ready", req_ready, 1);
        check("t6_idle_xfer", xfer_cnt, 16'd0);
        fill_log.delete();
        send_req(1'b0, 8'h00, 8'h02);
        wait_end(200);
        check("t6_latency", last_done_cyc - last_accept_cyc, 17);
        check("t6_last", fill_log[15], {4'hF, 32'h0000_010F});

        // Stray acks in IDLE, then back-to-back requests with req_valid held
        stray_ack = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        check("t7_stray_idle", {mem_req, req_ready}, 2'b01);
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        req_valid = 1'b1;
        req_wb = 1'b0;
        req_fill_blk = 8'h02;
        wait_accept(accept_cnt, 50);
        @(posedge clk);
        #1;
        req_fill_blk = 8'h11;
        wait_accept(accept_cnt, 100);
        done1 = last_done_cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t7_b2b_gap", last_accept_cyc - done1, 1);
        wait_end(200);
        check("t7_latency", last_done_cyc - last_accept_cyc, 17);
        @(negedge clk);
        #2;
        check("t7_xfer", xfer_cnt, 16'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/block_transfer_engine.md
Name: block_transfer_engine

Overview:
- Miss-handling stage directly downstream of the 4-way set-associative data cache.
- On a miss, the cache hands over the victim block (if dirty) and the refill block number. This engine writes the victim back to main memory word by word, then reads the 16 refill words and streams them into the cache data array.
- Sits between the cache controller and the word-wide main-memory port.

Parameters:
- DATA_W, 32, width of one cache/memory word (integer).
- BLK_W, 8, block-number width (256 blocks of memory).
- WORDS, 16, words per block. Must be a power of 2; the word index is log2(WORDS) = 4 bits.
- MAX_WAIT, 64, maximum cycles a beat may wait for mem_ack before abort.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  cache presents a miss-service request.
- req_ready  out  1  engine idle; request accepted when req_valid && req_ready.
- req_wb  in  1  victim is dirty; write back before fill.
- req_wb_blk  in  BLK_W  victim memory block number ({tag,set}).
- req_fill_blk  in  BLK_W  block number to fetch.
- wb_word_idx  out  4  word index of victim currently requested from the cache.
- wb_word  in  DATA_W  victim word; cache drives it combinationally from wb_word_idx.
- fill_valid  out  1  one-cycle strobe: fill_word is to be written into the cache.
- fill_word_idx  out  4  offset for fill_word.
- fill_word  out  DATA_W  refill data.
- done  out  1  one-cycle pulse: request completed successfully.
- err  out  1  one-cycle pulse: request aborted on timeout.
- mem_req  out  1  beat active.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  BLK_W+4  {block, word index}.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- mem_ack  in  1  beat complete when sampled high with mem_req high.
- xfer_cnt  out  16  number of completed requests, saturating at 0xFFFF.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All outputs 0 except req_ready = 1.
  - Word index, wait counter and xfer_cnt cleared.
  - Reset mid-transfer drops mem_req at once; no done or err is generated.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - req_ready = 1.
  - On accept, latch req_wb, req_wb_blk and req_fill_blk; idx = 0.
  - Next state is WB if req_wb, else FILL.
- WB:
  - mem_req = 1, mem_we = 1, mem_addr = {wb_blk, idx}, wb_word_idx = idx, mem_wdata = wb_word.
  - Outputs are held stable until mem_ack.
  - On ack: idx++. On the ack of idx 15: idx = 0 and next state is FILL.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {fill_blk, idx}.
  - On ack: the next cycle has fill_valid = 1, fill_word = registered mem_rdata, fill_word_idx = idx; then idx++.
  - On the ack of idx 15, next state is DONE.
- DONE:
  - done = 1 for one cycle.
  - xfer_cnt increments (saturating).
  - The last fill_valid coincides with this cycle.
  - Next state is IDLE.
- Beat sequencing:
  - mem_req stays high across consecutive beats; the address advances the cycle after each ack.
  - The memory counts one beat per sampled ack.
  - mem_ack while mem_req = 0 is ignored.
- Timeout:
  - The wait counter increments each cycle mem_req = 1 and mem_ack = 0, and clears on ack.
  - When it reaches MAX_WAIT: err = 1 for one cycle, mem_req drops, state = IDLE.
  - done is not pulsed and xfer_cnt is unchanged.
  - Any fill words already strobed are left in the cache; the cache keeps the line invalid.
- Latency with a zero-wait memory (ack in the first cycle of each beat), request accepted at cycle T:
  - Fill-only: beats at T+1..T+16, done at T+17, req_ready at T+18.
  - With write-back: add 16 cycles.
- Ordering and overlap:
  - req_wb_blk == req_fill_blk is legal; the write-back always completes before the first read.
  - req_valid in a non-IDLE state is not accepted; the request inputs are captured only at accept.

Test Plan:
- Fill-only, req_fill_blk = 0x02, memory word k = 0x100 + k, ack every cycle:
  - 16 fill_valid strobes with idx 0..15 and data 0x100..0x10F.
  - done at T+17, xfer_cnt = 1.
- Dirty miss, req_wb_blk = 0x85, req_fill_blk = 0x05, cache victim word k = 0xA0 + k:
  - Writes to mem_addr 0x850..0x85F carrying 0xA0..0xAF.
  - Then reads from 0x050..0x05F.
  - done at T+33.
- Wait states, memory acks every 3rd cycle during fill:
  - mem_addr stable between acks.
  - fill_word_idx strictly increasing 0..15.
  - No duplicate strobes.
- Timeout, memory never acks on beat 5 of the fill (MAX_WAIT = 64):
  - err pulses exactly 64 cycles after beat 5 starts.
  - mem_req = 0 and req_ready = 1 the next cycle.
  - No done; xfer_cnt unchanged.
- Reset asserted during the WB beat at idx 7:
  - mem_req, fill_valid and done go to 0 immediately.
  - After release: IDLE with req_ready = 1, xfer_cnt = 0.
  - A new request completes normally.
- Back-to-back requests with req_valid held high:
  - Second request accepted at the cycle after done.
  - Stray mem_ack pulses in IDLE are ignored.
